// File: rtl/bicubic_block_serializer.sv
// Serializes 4x4 upscaled blocks into a row-major sample stream with row/col/last tags.
// A two-slot ping-pong buffer lets one block be accepted while the other drains.
module bicubic_block_serializer #(
   parameter int CHANNEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     bcci_rsp_valid,
   output logic                     bf_rsp_ready,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data5,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data6,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data7,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data8,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data9,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data10,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data11,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data12,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data13,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data14,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data15,
   input  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data16,
   output logic                     ser_valid,
   input  logic                     ds_ready,
   output logic [CHANNEL_WIDTH-1:0] ser_data,
   output logic [1:0]               ser_row,
   output logic [1:0]               ser_col,
   output logic                     ser_last
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t                     state;
   occ_t                     state_nxt;
   logic [CHANNEL_WIDTH-1:0] slot [2][16];
   logic [CHANNEL_WIDTH-1:0] blk_in [16];
   logic                     wr_ptr;
   logic                     rd_ptr;
   logic [3:0]               idx;
   logic                     accept;
   logic                     take;
   logic                     rel;

   always_comb begin
      blk_in[0]  = bcci_rsp_data1;
      blk_in[1]  = bcci_rsp_data2;
      blk_in[2]  = bcci_rsp_data3;
      blk_in[3]  = bcci_rsp_data4;
      blk_in[4]  = bcci_rsp_data5;
      blk_in[5]  = bcci_rsp_data6;
      blk_in[6]  = bcci_rsp_data7;
      blk_in[7]  = bcci_rsp_data8;
      blk_in[8]  = bcci_rsp_data9;
      blk_in[9]  = bcci_rsp_data10;
      blk_in[10] = bcci_rsp_data11;
      blk_in[11] = bcci_rsp_data12;
      blk_in[12] = bcci_rsp_data13;
      blk_in[13] = bcci_rsp_data14;
      blk_in[14] = bcci_rsp_data15;
      blk_in[15] = bcci_rsp_data16;
   end

   assign accept = bcci_rsp_valid & bf_rsp_ready;
   assign take   = ser_valid & ds_ready;
   assign rel    = take & (idx == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (accept) state_nxt = HALF;
         HALF: begin
            if (accept && !rel)      state_nxt = FULL;
            else if (!accept && rel) state_nxt = EMPTY;
         end
         FULL:    if (rel) state_nxt = HALF;
         default: state_nxt = EMPTY;
      endcase
   end

   // Handshake qualifiers come from registered state only, so no comb path from ds_ready/valid
   always_comb begin
      bf_rsp_ready = (state != FULL);
      ser_valid    = (state != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < 2; s++)
            for (int unsigned i = 0; i < 16; i++)
               slot[s][i] <= '0;
         wr_ptr <= 1'b0;
      end else if (accept) begin
         for (int unsigned i = 0; i < 16; i++)
            slot[wr_ptr][i] <= blk_in[i];
         wr_ptr <= ~wr_ptr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         rd_ptr <= 1'b0;
      end else if (take) begin
         idx <= idx + 4'd1;
         if (rel) rd_ptr <= ~rd_ptr;
      end
   end

   assign ser_data = slot[rd_ptr][idx];
   assign ser_row  = idx[3:2];
   assign ser_col  = idx[1:0];
   assign ser_last = (idx == 4'd15);

endmodule

// File: tb/tb_bicubic_block_serializer.sv
// Directed bench for bicubic_block_serializer: ordering, tags, backpressure, full stall, reset.
module tb_bicubic_block_serializer;

   logic       clk;
   logic       rst_n;
   logic       bcci_rsp_valid;
   logic       bf_rsp_ready;
   logic [7:0] d [16];
   logic       ser_valid;
   logic       ds_ready;
   logic [7:0] ser_data;
   logic [1:0] ser_row;
   logic [1:0] ser_col;
   logic       ser_last;

   int total = 0;
   int bad   = 0;

   bicubic_block_serializer #(.CHANNEL_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
      .bcci_rsp_data1(d[0]),   .bcci_rsp_data2(d[1]),   .bcci_rsp_data3(d[2]),   .bcci_rsp_data4(d[3]),
      .bcci_rsp_data5(d[4]),   .bcci_rsp_data6(d[5]),   .bcci_rsp_data7(d[6]),   .bcci_rsp_data8(d[7]),
      .bcci_rsp_data9(d[8]),   .bcci_rsp_data10(d[9]),  .bcci_rsp_data11(d[10]), .bcci_rsp_data12(d[11]),
      .bcci_rsp_data13(d[12]), .bcci_rsp_data14(d[13]), .bcci_rsp_data15(d[14]), .bcci_rsp_data16(d[15]),
      .ser_valid(ser_valid), .ds_ready(ds_ready), .ser_data(ser_data),
      .ser_row(ser_row), .ser_col(ser_col), .ser_last(ser_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_blk(input logic [7:0] base);
      for (int n = 0; n < 16; n++) d[n] = base + 8'(n);
   endtask

   task automatic chk_sample(input string tag, input logic [7:0] exp_data, input int exp_idx);
      logic [3:0] ei;
      ei = 4'(exp_idx);
      chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
      chk({tag, "_data"},  32'(ser_data),  32'(exp_data));
      chk({tag, "_row"},   32'(ser_row),   32'(ei[3:2]));
      chk({tag, "_col"},   32'(ser_col),   32'(ei[1:0]));
      chk({tag, "_last"},  32'(ser_last),  32'(exp_idx == 15));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_valid"}, 32'(ser_valid),    32'd0);
      chk({tag, "_data"},  32'(ser_data),     32'd0);
      chk({tag, "_row"},   32'(ser_row),      32'd0);
      chk({tag, "_col"},   32'(ser_col),      32'd0);
      chk({tag, "_last"},  32'(ser_last),     32'd0);
      chk({tag, "_ready"}, 32'(bf_rsp_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_d;
      logic       exp_rdy;

      rst_n = 1'b0;
      bcci_rsp_valid = 1'b0;
      ds_ready = 1'b1;
      set_blk(8'h00);
      #1;
      chk_reset_outs("por");
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_reset_outs("idle");

      // Single block
      set_blk(8'h01);
      bcci_rsp_valid = 1'b1;
      step();
      bcci_rsp_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_sample("single", 8'(k + 1), k);
         step();
      end
      chk("single_after_valid", 32'(ser_valid), 32'd0);

      // Back-to-back A then B
      set_blk(8'h01);
      bcci_rsp_valid = 1'b1;
      step();
      for (int k = 0; k < 32; k++) begin
         exp_d   = (k < 16) ? 8'(k + 1) : 8'(8'h21 + k - 16);
         exp_rdy = !(k >= 1 && k <= 15);
         chk_sample("b2b", exp_d, k % 16);
         chk("b2b_ready", 32'(bf_rsp_ready), 32'(exp_rdy));
         if (k == 0) set_blk(8'h21);
         if (k == 1) bcci_rsp_valid = 1'b0;
         step();
      end
      chk("b2b_after_valid", 32'(ser_valid), 32'd0);

      // Backpressure holding sample 0x07
      set_blk(8'h01);
      bcci_rsp_valid = 1'b1;
      step();
      bcci_rsp_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_sample("bp", 8'(k + 1), k);
         if (k == 6) begin
            ds_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               step();
               chk_sample("bp_hold", 8'h07, 6);
            end
            ds_ready = 1'b1;
         end
         step();
      end
      chk("bp_after_valid", 32'(ser_valid), 32'd0);

      // Full stall: C offered while FULL, held until ready returns
      set_blk(8'h01);
      bcci_rsp_valid = 1'b1;
      step();
      for (int k = 0; k < 48; k++) begin
         if (k < 16)      exp_d = 8'(k + 1);
         else if (k < 32) exp_d = 8'(8'h21 + k - 16);
         else             exp_d = 8'(8'h61 + k - 32);
         exp_rdy = (k == 0) || (k == 16) || (k >= 32);
         chk_sample("stall", exp_d, k % 16);
         chk("stall_ready", 32'(bf_rsp_ready), 32'(exp_rdy));
         if (k == 0) set_blk(8'h21);
         if (k == 1) set_blk(8'h61);
         if (k == 17) bcci_rsp_valid = 1'b0;
         step();
      end
      chk("stall_after_valid", 32'(ser_valid), 32'd0);

      // Reset mid-drain at sample 9
      set_blk(8'h01);
      bcci_rsp_valid = 1'b1;
      step();
      bcci_rsp_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk_sample("pre_rst", 8'h09, 8);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("async_rst");
      #1;
      rst_n = 1'b1;
      step();
      chk_reset_outs("post_rst");
      set_blk(8'h41);
      bcci_rsp_valid = 1'b1;
      step();
      bcci_rsp_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_sample("blkd", 8'(8'h41 + k), k);
         step();
      end
      chk("blkd_after_valid", 32'(ser_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
